// File: rtl/user_rr_merge_i7o1.sv
// Seven-stream round-robin merge into one output stream through a small FIFO.
// Latency: 1 cycle input-to-output when the FIFO is empty; backpressure: all acks drop while the FIFO is full.
// Output holds its head word stable until accepted.
module user_rr_merge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // full is registered, so a slot freed by a pop is only offered for push on the next cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign full_o     = full_q;
    assign count_o    = count_q;
endmodule

module user_rr_merge_i7o1 #(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_user,
    input  logic                          reset,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_1,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_2,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_3,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_4,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_5,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_6,
    input  logic [PAYLOAD_BITS-1:0]       dout_leaf_interface2user_7,
    input  logic                          vld_interface2user_1,
    input  logic                          vld_interface2user_2,
    input  logic                          vld_interface2user_3,
    input  logic                          vld_interface2user_4,
    input  logic                          vld_interface2user_5,
    input  logic                          vld_interface2user_6,
    input  logic                          vld_interface2user_7,
    output logic                          ack_user2interface_1,
    output logic                          ack_user2interface_2,
    output logic                          ack_user2interface_3,
    output logic                          ack_user2interface_4,
    output logic                          ack_user2interface_5,
    output logic                          ack_user2interface_6,
    output logic                          ack_user2interface_7,
    output logic [PAYLOAD_BITS-1:0]       din_leaf_user2interface_1,
    output logic                          vld_user2interface_1,
    input  logic                          ack_interface2user_1,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   word_count
);
    logic [PAYLOAD_BITS-1:0] in_dat [7];
    logic [6:0]              in_vld, ack_vec;
    logic [2:0]              ptr_q, ptr_d;
    logic [31:0]             word_count_q, word_count_d;
    logic                    full, empty, push, pop;
    logic [PAYLOAD_BITS-1:0] push_dat;

    assign in_dat[0] = dout_leaf_interface2user_1;
    assign in_dat[1] = dout_leaf_interface2user_2;
    assign in_dat[2] = dout_leaf_interface2user_3;
    assign in_dat[3] = dout_leaf_interface2user_4;
    assign in_dat[4] = dout_leaf_interface2user_5;
    assign in_dat[5] = dout_leaf_interface2user_6;
    assign in_dat[6] = dout_leaf_interface2user_7;
    assign in_vld = {vld_interface2user_7, vld_interface2user_6, vld_interface2user_5,
                     vld_interface2user_4, vld_interface2user_3, vld_interface2user_2,
                     vld_interface2user_1};
    assign {ack_user2interface_7, ack_user2interface_6, ack_user2interface_5,
            ack_user2interface_4, ack_user2interface_3, ack_user2interface_2,
            ack_user2interface_1} = ack_vec;

    // Acks come purely from ptr_q and the registered full flag, never from any vld
    always_comb begin
        ack_vec  = '0;
        push_dat = '0;
        for (int k = 0; k < 7; k++) begin
            if (ptr_q == 3'(k + 1)) begin
                ack_vec[k] = !full && reset;
                push_dat   = in_dat[k];
            end
        end
    end

    assign push = |(ack_vec & in_vld);
    assign vld_user2interface_1 = !empty && reset;
    assign pop  = vld_user2interface_1 && ack_interface2user_1;

    // The pointer moves on whether or not the offered stream had data
    always_comb begin
        ptr_d = ptr_q;
        if (!full) begin
            ptr_d = (ptr_q == 3'd7) ? 3'd1 : ptr_q + 3'd1;
        end
    end

    assign word_count_d = word_count_q + (pop ? 32'd1 : 32'd0);

    always_ff @(posedge clk_user) begin
        if (!reset) begin
            ptr_q        <= 3'd1;
            word_count_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;

    user_rr_merge_fifo #(
        .W     (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_user),
        .rst_n_i    (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (din_leaf_user2interface_1),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (fifo_count)
    );
endmodule

// File: tb/tb_user_rr_merge_i7o1.sv
// Bench for user_rr_merge_i7o1: queue-based reference model, decoupled output scoreboard.
module tb_user_rr_merge_i7o1;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_vld [1:7];
    logic [31:0] in_dat [1:7];
    logic        ack_o  [1:7];
    logic [31:0] din;
    logic        vld_o;
    logic        out_ack;
    logic [2:0]  fifo_count;
    logic [31:0] word_count;
    logic [6:0]  dut_ack;

    int checks = 0;
    int errors = 0;

    // reference model state (owned by the stimulus process)
    int          m_ptr = 1;
    int          m_cnt = 0;
    logic [31:0] m_wc  = '0;
    logic [31:0] exp_q [$];
    int          flush_to = 0;
    logic [31:0] obs [$];

    bit auto_stim = 0;
    bit fixed_dat = 0;
    bit ack_rand  = 0;
    bit mon_en    = 0;
    int p_vld [1:7];

    user_rr_merge_i7o1 #(.PAYLOAD_BITS(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk_user                   (clk),
        .reset                      (rst_n),
        .dout_leaf_interface2user_1 (in_dat[1]),
        .dout_leaf_interface2user_2 (in_dat[2]),
        .dout_leaf_interface2user_3 (in_dat[3]),
        .dout_leaf_interface2user_4 (in_dat[4]),
        .dout_leaf_interface2user_5 (in_dat[5]),
        .dout_leaf_interface2user_6 (in_dat[6]),
        .dout_leaf_interface2user_7 (in_dat[7]),
        .vld_interface2user_1       (in_vld[1]),
        .vld_interface2user_2       (in_vld[2]),
        .vld_interface2user_3       (in_vld[3]),
        .vld_interface2user_4       (in_vld[4]),
        .vld_interface2user_5       (in_vld[5]),
        .vld_interface2user_6       (in_vld[6]),
        .vld_interface2user_7       (in_vld[7]),
        .ack_user2interface_1       (ack_o[1]),
        .ack_user2interface_2       (ack_o[2]),
        .ack_user2interface_3       (ack_o[3]),
        .ack_user2interface_4       (ack_o[4]),
        .ack_user2interface_5       (ack_o[5]),
        .ack_user2interface_6       (ack_o[6]),
        .ack_user2interface_7       (ack_o[7]),
        .din_leaf_user2interface_1  (din),
        .vld_user2interface_1       (vld_o),
        .ack_interface2user_1       (out_ack),
        .fifo_count                 (fifo_count),
        .word_count                 (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_ack = '0;
        for (int k = 1; k <= 7; k++) dut_ack[k-1] = ack_o[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of the reference: the slot offered is m_ptr, and it is offered only when not full
    task automatic model_step();
        bit full, push, pop;
        if (!rst_n) begin
            m_ptr = 1; m_cnt = 0; m_wc = '0;
            flush_to = exp_q.size();
        end else begin
            full = (m_cnt == DEPTH);
            pop  = (m_cnt > 0) && out_ack;
            push = !full && in_vld[m_ptr];
            if (push) exp_q.push_back(in_dat[m_ptr]);
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (pop) m_wc = m_wc + 32'd1;
            if (!full) m_ptr = (m_ptr % 7) + 1;
        end
    endtask

    task automatic regen(input int k);
        in_vld[k] = ($urandom_range(99) < p_vld[k]);
        in_dat[k] = fixed_dat ? 32'h100 + 32'(k) : $urandom;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (auto_stim) for (int k = 1; k <= 7; k++) regen(k);
        if (ack_rand) out_ack = ($urandom_range(99) < 60);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_p(input int p);
        for (int k = 1; k <= 7; k++) p_vld[k] = p;
    endtask

    // Output monitor / scoreboard
    initial begin
        int          rd_idx = 0;
        bit          hold_prev = 0;
        logic [31:0] prev_din = '0;
        logic [6:0]  exp_ack;
        wait (mon_en);
        forever begin
            @(negedge clk);
            exp_ack = '0;
            if (rst_n && m_cnt < DEPTH) exp_ack[m_ptr-1] = 1'b1;
            chk("acks", 32'(dut_ack), 32'(exp_ack));
            chk("out_vld", 32'(vld_o), 32'(rst_n && m_cnt > 0));
            chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
            chk("word_count", word_count, m_wc);
            if (rd_idx < flush_to) rd_idx = flush_to;
            if (hold_prev && vld_o) chk("din_hold", din, prev_din);
            if (vld_o && out_ack) begin
                if (rd_idx < exp_q.size()) begin
                    chk("din_order", din, exp_q[rd_idx]);
                    rd_idx++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL din_order: got %h expected no word", din);
                end
                obs.push_back(din);
            end
            hold_prev = vld_o && !out_ack;
            prev_din  = din;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int base;
        int waited;
        rst_n   = 1'b0;
        out_ack = 1'b0;
        set_p(0);
        for (int k = 1; k <= 7; k++) begin in_vld[k] = 1'b0; in_dat[k] = '0; end
        @(negedge clk);
        mon_en = 1;

        // Single word on stream 1
        out_ack = 1'b1;
        do_reset();
        in_vld[1] = 1'b1;
        in_dat[1] = 32'hA5A5_0001;
        #1 chk("t1_ack1_after_reset", 32'(ack_o[1]), 32'd1);
        cycle();
        in_vld[1] = 1'b0;
        repeat (3) cycle();
        chk("t1_word_count", word_count, 32'd1);
        if (obs.size() > 0) chk("t1_payload", obs[obs.size()-1], 32'hA5A5_0001);
        else chk("t1_payload_seen", 32'(obs.size()), 32'd1);

        // All streams valid, fixed payloads 0x100+k
        auto_stim = 1; fixed_dat = 1; set_p(100);
        do_reset();
        base = obs.size();
        repeat (20) cycle();
        if (obs.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) chk("t2_order", obs[base+i], 32'h101 + 32'(i % 7));
        end else chk("t2_word_total", 32'(obs.size() - base), 32'd8);

        // Only stream 5 valid
        set_p(0); p_vld[5] = 100;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            chk("t3_ack5_cycle", 32'(ack_o[5]), 32'((c == 5) || (c == 12)));
            cycle();
        end

        // Output stalled: fill, then drain
        fixed_dat = 0; set_p(100); out_ack = 1'b0;
        do_reset();
        repeat (10) cycle();
        chk("t4_full_count", 32'(fifo_count), 32'(DEPTH));
        chk("t4_acks_low", 32'(dut_ack), 32'd0);
        base = obs.size();
        out_ack = 1'b1;
        repeat (12) cycle();
        chk("t4_drained", 32'(obs.size() >= base + DEPTH), 32'd1);

        // Reset while the FIFO holds three words
        repeat (4) cycle();
        out_ack = 1'b0;
        waited = 0;
        while (m_cnt != 3 && waited < 20) begin cycle(); waited++; end
        chk("t5_count3", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        cycle();
        chk("t5_fifo_count", 32'(fifo_count), 32'd0);
        chk("t5_vld", 32'(vld_o), 32'd0);
        chk("t5_word_count", word_count, 32'd0);
        chk("t5_acks_in_reset", 32'(dut_ack), 32'd0);
        rst_n = 1'b1;
        #1 chk("t5_ptr1", 32'(dut_ack), 32'd1);
        repeat (3) cycle();

        // Randomized traffic with random output backpressure and one mid-run reset
        ack_rand = 1;
        for (int k = 1; k <= 7; k++) p_vld[k] = $urandom_range(100);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
                for (int k = 1; k <= 7; k++) p_vld[k] = $urandom_range(100);
            end
            cycle();
        end
        ack_rand = 0;

        // word_count wrap from all-ones
        set_p(100); out_ack = 1'b0;
        do_reset();
        repeat (2) cycle();
        force dut.word_count_q = 32'hFFFF_FFFF;
        m_wc = 32'hFFFF_FFFF;
        cycle();
        release dut.word_count_q;
        chk("t7_preset", word_count, 32'hFFFF_FFFF);
        out_ack = 1'b1;
        cycle();
        chk("t7_wrap", word_count, 32'd0);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
